// File: rtl/e203_dtcm_icb_master.sv
// ICB master that fills a DTCM region with an incrementing pattern or
// checksums it, one transaction outstanding at a time.
module e203_dtcm_icb_master #(
  parameter int AW = 16,
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  input  logic [31:0]   pattern,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   result,
  output logic          icb_cmd_valid,
  input  logic          icb_cmd_ready,
  output logic [AW-1:0] icb_cmd_addr,
  output logic          icb_cmd_read,
  output logic [31:0]   icb_cmd_wdata,
  output logic [3:0]    icb_cmd_wmask,
  input  logic          icb_rsp_valid,
  output logic          icb_rsp_ready,
  input  logic          icb_rsp_err,
  input  logic [31:0]   icb_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

  state_t        state, state_nxt;
  logic          op_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] index;
  logic [31:0]   wdata_q;
  logic [31:0]   sum, sum_nxt;
  logic          abort_flag;
  logic          cmd_pend;
  logic          cmd_kill;
  logic          rsp_hs;
  logic          last;

  // An abort may only suppress a command that has never been shown on the bus;
  // cmd_pend marks a command that was presented but not yet accepted.
  always_comb begin
    rsp_hs   = (state == RSP) && icb_rsp_valid;
    last     = ((index + LW'(1)) == len_q);
    cmd_kill = (state == CMD) && !cmd_pend && (abort || abort_flag);
    sum_nxt  = sum;
    if (rsp_hs && !icb_rsp_err && op_q) sum_nxt = sum + icb_rsp_rdata;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : CMD;
      CMD: begin
        if (cmd_kill)           state_nxt = DONE;
        else if (icb_cmd_ready) state_nxt = RSP;
      end
      RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err || last || abort || abort_flag) state_nxt = DONE;
          else                                            state_nxt = CMD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign icb_cmd_valid = (state == CMD) && !cmd_kill;
  assign icb_rsp_ready = (state == RSP);
  assign icb_cmd_addr  = (state == CMD) ? addr_q : '0;
  assign icb_cmd_read  = (state == CMD) && op_q;
  assign icb_cmd_wdata = ((state == CMD) && !op_q) ? wdata_q : 32'h0;
  assign icb_cmd_wmask = ((state == CMD) && !op_q) ? 4'hF : 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      index      <= '0;
      wdata_q    <= 32'h0;
      sum        <= 32'h0;
      err        <= 1'b0;
      result     <= 32'h0;
      abort_flag <= 1'b0;
      cmd_pend   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (start) begin
          op_q       <= op;
          addr_q     <= base_addr & ~AW'(3);
          len_q      <= len;
          wdata_q    <= pattern;
          index      <= '0;
          sum        <= 32'h0;
          err        <= 1'b0;
          result     <= 32'h0;
          abort_flag <= 1'b0;
          cmd_pend   <= 1'b0;
        end
      end else begin
        if (abort) abort_flag <= 1'b1;
        cmd_pend <= icb_cmd_valid && !icb_cmd_ready;
        if (rsp_hs) begin
          if (icb_rsp_err) begin
            err <= 1'b1;
          end else begin
            index   <= index + LW'(1);
            addr_q  <= addr_q + AW'(4);
            wdata_q <= wdata_q + 32'd1;
            sum     <= sum_nxt;
          end
        end
        if (state != DONE && state_nxt == DONE) result <= sum_nxt;
      end
    end
  end

endmodule

// File: tb/tb_e203_dtcm_icb_master.sv
// Randomised scoreboard bench: expected commands and completions are queued
// from a job-level model, a monitor pops and compares them as the DUT emits.
module tb_e203_dtcm_icb_master;
  localparam int AW = 16;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic [31:0]   pattern = 32'h0;
  logic          abort = 1'b0;
  logic          busy, done, err;
  logic [31:0]   result;
  logic          icb_cmd_valid;
  logic          icb_cmd_ready = 1'b0;
  logic [AW-1:0] icb_cmd_addr;
  logic          icb_cmd_read;
  logic [31:0]   icb_cmd_wdata;
  logic [3:0]    icb_cmd_wmask;
  logic          icb_rsp_valid = 1'b0;
  logic          icb_rsp_ready;
  logic          icb_rsp_err = 1'b0;
  logic [31:0]   icb_rsp_rdata = 32'h0;

  e203_dtcm_icb_master #(.AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base_addr(base_addr),
    .len(len), .pattern(pattern), .abort(abort), .busy(busy), .done(done),
    .err(err), .result(result), .icb_cmd_valid(icb_cmd_valid),
    .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata),
    .icb_cmd_wmask(icb_cmd_wmask), .icb_rsp_valid(icb_rsp_valid),
    .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          read;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
  } cmd_t;

  typedef struct packed {
    logic [31:0] result;
    logic        err;
  } fin_t;

  cmd_t cmd_exp[$];
  fin_t fin_exp[$];
  int total = 0;
  int bad = 0;

  logic [31:0] rdata_tbl [0:4095];
  int err_word = -1;
  int abort_word = -1;
  int ready_lag = 0;
  int rsp_delay = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s", name);
  endtask

  // Job-level model: which words get issued, what they carry, how the job ends.
  task automatic modelJob(input bit o, input logic [AW-1:0] b, input int n,
                          input logic [31:0] p, input int ew, input int aw,
                          output fin_t fin);
    int ncmd = n;
    logic [31:0] s = 32'h0;
    bit e = 1'b0;
    cmd_t c;
    if (ew >= 0 && ew + 1 < ncmd) ncmd = ew + 1;
    if (aw >= 0 && aw + 1 < ncmd) ncmd = aw + 1;
    for (int i = 0; i < ncmd; i++) begin
      c.addr  = (b & 16'hFFFC) + AW'(4 * i);
      c.read  = o;
      c.wdata = o ? 32'h0 : p + 32'(i);
      c.wmask = o ? 4'h0 : 4'hF;
      cmd_exp.push_back(c);
      if (i == ew) e = 1'b1;
      else if (o) s = s + rdata_tbl[i];
    end
    fin.result = s;
    fin.err    = e;
    fin_exp.push_back(fin);
  endtask

  task automatic applyStimulus(input bit o, input logic [AW-1:0] b, input int n,
                               input logic [31:0] p, input int ew, input int aw,
                               input int lag, input int dly, input bit glitch,
                               input int exp_cycles);
    fin_t fin;
    int cycles;
    bit got = 1'b0;
    err_word = ew; abort_word = aw; ready_lag = lag; rsp_delay = dly;
    modelJob(o, b, n, p, ew, aw, fin);
    @(posedge clk); #1;
    op = o; base_addr = b; len = LW'(n); pattern = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); base_addr = AW'($urandom);
    len = LW'($urandom); pattern = $urandom;
    cycles = 1;
    while (cycles < 4000 && !got) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1'b1;
      else if (glitch && cycles == 5 && busy) begin
        start = 1'b1;
        @(negedge clk);
        cycles++;
        start = 1'b0;
        if (done) got = 1'b1;
      end
    end
    if (!got) begin
      failNow("done_timeout");
      cmd_exp.delete();
      fin_exp.delete();
    end else if (exp_cycles > 0) begin
      checkOutput("done_latency", 32'(cycles), 32'(exp_cycles));
    end
    @(negedge clk);
    checkOutput("done_width", 32'(done), 32'h0);
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("result_hold", result, fin.result);
    checkOutput("err_hold", 32'(err), 32'(fin.err));
    checkOutput("cmds_left", 32'(cmd_exp.size()), 32'h0);
    checkOutput("fins_left", 32'(fin_exp.size()), 32'h0);
  endtask

  task automatic randomData(input int n);
    for (int i = 0; i < n; i++) rdata_tbl[i] = $urandom;
  endtask

  // Responder: ready after a configurable stall, response after a fixed delay,
  // abort raised while the chosen word is waiting for its response.
  initial begin : responder
    int cmd_word, pend_word, wait_cnt, stall;
    bit pending, cmd_hs, rsp_hs, vld, saw_start, saw_done;
    cmd_word = 0; pend_word = 0; wait_cnt = 0; stall = 0; pending = 1'b0;
    forever begin
      @(negedge clk);
      cmd_hs    = icb_cmd_valid && icb_cmd_ready;
      rsp_hs    = icb_rsp_valid && icb_rsp_ready;
      vld       = icb_cmd_valid;
      saw_start = start && !busy;
      saw_done  = done;
      @(posedge clk); #1;
      if (!rst_n) begin
        pending = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0;
        abort = 1'b0; stall = 0; icb_cmd_ready = 1'b0;
      end else begin
        if (saw_start) cmd_word = 0;
        if (saw_done) abort = 1'b0;
        if (rsp_hs) begin
          icb_rsp_valid = 1'b0;
          icb_rsp_err   = 1'b0;
        end
        if (cmd_hs) begin
          pending   = 1'b1;
          pend_word = cmd_word;
          cmd_word++;
          wait_cnt  = rsp_delay;
          stall     = 0;
          if (pend_word == abort_word) abort = 1'b1;
        end else if (vld) begin
          stall++;
        end
        if (pending && !icb_rsp_valid) begin
          if (wait_cnt == 0) begin
            icb_rsp_valid = 1'b1;
            icb_rsp_rdata = rdata_tbl[pend_word];
            icb_rsp_err   = (pend_word == err_word);
            pending       = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        icb_cmd_ready = (stall >= ready_lag);
      end
    end
  end

  initial begin : monitor
    bit outstanding, prev_stall;
    cmd_t cur, prev, e;
    fin_t f;
    outstanding = 1'b0; prev_stall = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 1'b0;
        prev_stall  = 1'b0;
      end else begin
        cur.addr = icb_cmd_addr; cur.read = icb_cmd_read;
        cur.wdata = icb_cmd_wdata; cur.wmask = icb_cmd_wmask;
        if (icb_cmd_valid) begin
          if (outstanding) failNow("two_outstanding");
          if (prev_stall) checkOutput("payload_stable", 32'(cur == prev), 32'h1);
          if (cmd_exp.size() == 0) begin
            failNow("unexpected_cmd_valid");
          end else if (icb_cmd_ready) begin
            e = cmd_exp.pop_front();
            checkOutput("cmd_addr", 32'(cur.addr), 32'(e.addr));
            checkOutput("cmd_read", 32'(cur.read), 32'(e.read));
            checkOutput("cmd_wdata", cur.wdata, e.wdata);
            checkOutput("cmd_wmask", 32'(cur.wmask), 32'(e.wmask));
          end
          if (icb_cmd_ready) outstanding = 1'b1;
        end
        prev_stall = icb_cmd_valid && !icb_cmd_ready;
        prev = cur;
        if (icb_rsp_valid && icb_rsp_ready) outstanding = 1'b0;
        if (done) begin
          if (fin_exp.size() == 0) begin
            failNow("unexpected_done");
          end else begin
            f = fin_exp.pop_front();
            checkOutput("done_result", result, f.result);
            checkOutput("done_err", 32'(err), 32'(f.err));
            checkOutput("done_busy", 32'(busy), 32'h1);
          end
        end
      end
    end
  end

  initial begin : main
    int n, ew, aw, guard;
    bit seen;
    #3;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_cmd_valid", 32'(icb_cmd_valid), 32'h0);
    checkOutput("rst_rsp_ready", 32'(icb_rsp_ready), 32'h0);
    checkOutput("rst_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] fill, checksum, backpressure");
    applyStimulus(1'b0, 16'h0100, 3, 32'hA0, -1, -1, 0, 0, 1'b0, 8);
    rdata_tbl[0] = 32'h1; rdata_tbl[1] = 32'h2;
    rdata_tbl[2] = 32'h3; rdata_tbl[3] = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 16'h0000, 4, 32'h0, -1, -1, 0, 0, 1'b0, 10);
    randomData(4);
    applyStimulus(1'b0, 16'h2002, 4, $urandom, -1, -1, 5, 3, 1'b0, 0);

    $display("[TB] error response, idle reset");
    randomData(8);
    applyStimulus(1'b1, 16'h0400, 8, 32'h0, 2, -1, 1, 1, 1'b0, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("idle_rst_result", result, 32'h0);
    checkOutput("idle_rst_err", 32'(err), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] len zero, address wrap, abort");
    applyStimulus(1'b0, 16'h1234, 0, 32'h5, -1, -1, 0, 0, 1'b0, 2);
    applyStimulus(1'b0, 16'hFFFC, 2, 32'h77, -1, -1, 0, 0, 1'b0, 6);
    randomData(10);
    applyStimulus(1'b1, 16'h0800, 10, 32'h0, -1, 1, 0, 2, 1'b0, 0);

    $display("[TB] reset mid-job");
    randomData(50);
    err_word = -1; abort_word = -1; ready_lag = 2; rsp_delay = 1;
    begin
      fin_t dummy;
      modelJob(1'b0, 16'h3000, 50, 32'hCAFE_0000, -1, -1, dummy);
    end
    @(posedge clk); #1;
    op = 1'b0; base_addr = 16'h3000; len = LW'(50); pattern = 32'hCAFE_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    guard = 0;
    while (!icb_cmd_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_done", 32'(done), 32'h0);
    checkOutput("mid_rst_cmd_valid", 32'(icb_cmd_valid), 32'h0);
    checkOutput("mid_rst_rsp_ready", 32'(icb_rsp_ready), 32'h0);
    checkOutput("mid_rst_addr", 32'(icb_cmd_addr), 32'h0);
    checkOutput("mid_rst_read", 32'(icb_cmd_read), 32'h0);
    checkOutput("mid_rst_wdata", icb_cmd_wdata, 32'h0);
    checkOutput("mid_rst_wmask", 32'(icb_cmd_wmask), 32'h0);
    cmd_exp.delete();
    fin_exp.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || icb_cmd_valid || busy) seen = 1'b1;
    end
    checkOutput("quiet_after_reset", 32'(seen), 32'h0);

    $display("[TB] random jobs");
    for (int j = 0; j < 40; j++) begin
      n  = $urandom_range(0, 12);
      ew = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      aw = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      randomData(n);
      applyStimulus(1'($urandom), AW'($urandom), n, $urandom, ew, aw,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
